data_bus_arbiter: RTL and testbench
===================================

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: maximum beats one master may hold the bus under lock (range 1..255).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have, for each master x in {0,1}:
- mx_req, input, 1: beat request.
- mx_lock, input, 1: keep ownership after this beat.
- mx_addr, input, AW: address.
- mx_wdata, input, 32: write data.
- mx_wenable, input, 4: byte write enables; 0 means read.
- mx_gnt, output, 1: beat accepted this cycle.
- mx_rvalid, output, 1: read data valid.
- mx_rdata, output, 32: read data.
REQ-007 SHALL have slave ports:
- s_addr, output, AW.
- s_wdata, output, 32.
- s_wenable, output, 4.
- s_rdata, input, 32: slave read data, valid one cycle after address (synchronous RAM).

Function
REQ-008 SHALL accept one beat per cycle, and SHALL grant at most one master per cycle.
REQ-009 SHALL hold FSM states IDLE, OWN0 and OWN1, plus a last_grant bit and a burst counter of width clog2(MAX_BURST+1).
REQ-010 SHALL apply these IDLE rules:
- One requester: grant it.
- Both requesting: grant the master != last_grant.
- None requesting: no grant.
REQ-011 SHALL assert mx_gnt combinationally in the same cycle as mx_req; the master holds its signals until granted.
REQ-012 SHALL drive the granted master's addr, wdata and wenable onto s_*.
- With no grant: s_wenable=0, s_addr=m0_addr, s_wdata=m0_wdata.
REQ-013 SHALL, on every granted beat, set last_grant to the granted master at the next edge.
REQ-014 SHALL, on a beat granted in IDLE with mx_lock=1 and MAX_BURST>1, enter OWNx with counter=1; otherwise it stays in IDLE.
REQ-015 SHALL apply these OWNx rules:
- Only master x is grantable; the other master's req is ignored.
- mx_gnt = mx_req.
- The counter increments per granted beat.
REQ-016 SHALL leave OWNx for IDLE at the next edge when any of these hold:
- mx_lock=0 (with or without a beat that cycle).
- A granted beat brings the counter to MAX_BURST.
REQ-017 SHALL clear the burst counter on every entry to IDLE.
REQ-018 SHALL NOT let the owner win the first IDLE arbitration after a forced MAX_BURST release when the other master is requesting, because last_grant=x.
REQ-019 SHALL return reads with latency 1: a read beat granted at cycle t sets mx_rvalid=1 at t+1 only, with mx_rdata=s_rdata.
REQ-020 SHALL drive mx_rdata=0 whenever mx_rvalid=0.
REQ-021 SHALL NOT assert mx_rvalid for write beats (mx_wenable!=0).
REQ-022 SHALL return rdata in grant order without loss on back-to-back reads, including reads alternating between masters.
REQ-023 SHALL, when a master drops mx_req in a cycle without a grant, take no action; no beat is recorded.

Reset
REQ-024 SHALL, while rst=1 at a rising edge, set the following at that edge, overriding any in-flight beat:
- state=IDLE, last_grant=1, counter=0.
- m0_rvalid=m1_rvalid=0.
REQ-025 SHALL, during the rst=1 cycle, drive m0_gnt=m1_gnt=0 and s_wenable=0.
REQ-026 SHALL drop a read granted in the cycle before reset: its rvalid is never asserted.
REQ-027 SHALL, on the first arbitration after reset with both masters requesting, grant m0.

Verification
REQ-028 SHALL cover tie after reset: m0 and m1 request reads to 0x10 and 0x20 every cycle.
- Required: grants alternate m0, m1, m0, m1.
- Each rvalid one cycle after its gnt, carrying the RAM word at the matching address.
REQ-029 SHALL cover a locked burst: with MAX_BURST=4, m1 requests continuously, and m0 requests continuously with lock=1.
- Required: m0 granted 4 consecutive cycles, then m1 granted once, then m0 again.
REQ-030 SHALL cover a short lock: m0 locks for 2 beats, then drops lock in the same cycle as its 2nd beat while m1 is requesting.
- Required: next cycle returns to IDLE and m1 is granted.
REQ-031 SHALL cover a write: m1 writes 0xDEADBEEF to 0x40 with wenable=4'b0011 while m0 is idle.
- Required: s_wenable=0011 and s_wdata=0xDEADBEEF that cycle, and m1_rvalid is never asserted.
- A subsequent m0 read of 0x40 returns the merged word.
REQ-032 SHALL cover reset mid-operation: assert rst the cycle after an m0 read grant while in OWN0.
- Required: m0_rvalid=0 next cycle, state IDLE.
- Next tie grants m0.
REQ-033 SHALL cover an idle bus: no requests for 10 cycles.
- Required: no gnt, no rvalid, s_wenable=0, last_grant unchanged.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave beat arbiter with lockable bursts and fixed-latency read return.
// Ties in IDLE go to the master that did not win last; a locked owner keeps the bus for up to MAX_BURST beats.
module data_bus_arbiter #(
   parameter int MAX_BURST = 8,
   parameter int AW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic [3:0]    m0_wenable,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   input  logic          m1_req,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic [3:0]    m1_wenable,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic [AW-1:0] s_addr,
   output logic [31:0]   s_wdata,
   output logic [3:0]    s_wenable,
   input  logic [31:0]   s_rdata
);

   localparam int CW       = $clog2(MAX_BURST + 1);
   localparam bit CAN_LOCK = (MAX_BURST > 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_inc;
   logic            rvalid0_q, rvalid0_d;
   logic            rvalid1_q, rvalid1_d;
   logic            req0, req1;
   logic            gnt0, gnt1;

   // Requests are masked during reset so nothing is granted or driven in that cycle.
   assign req0    = m0_req & ~rst;
   assign req1    = m1_req & ~rst;
   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               gnt0 = last_grant_q;
               gnt1 = ~last_grant_q;
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
            if (gnt0 && m0_lock && CAN_LOCK) begin
               state_d = OWN0;
               cnt_d   = CW'(1);
            end else if (gnt1 && m1_lock && CAN_LOCK) begin
               state_d = OWN1;
               cnt_d   = CW'(1);
            end
         end
         OWN0: begin
            gnt0 = req0;
            if (gnt0) cnt_d = cnt_inc;
            if (!m0_lock || (gnt0 && cnt_inc == CW'(MAX_BURST))) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            gnt1 = req1;
            if (gnt1) cnt_d = cnt_inc;
            if (!m1_lock || (gnt1 && cnt_inc == CW'(MAX_BURST))) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      endcase
      if (gnt0) last_grant_d = 1'b0;
      if (gnt1) last_grant_d = 1'b1;
   end

   assign rvalid0_d = gnt0 && (m0_wenable == 4'b0000);
   assign rvalid1_d = gnt1 && (m1_wenable == 4'b0000);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
      end
   end

   always_comb begin
      s_addr    = m0_addr;
      s_wdata   = m0_wdata;
      s_wenable = 4'b0000;
      if (gnt1) begin
         s_addr    = m1_addr;
         s_wdata   = m1_wdata;
         s_wenable = m1_wenable;
      end else if (gnt0) begin
         s_wenable = m0_wenable;
      end
   end

   assign m0_gnt = gnt0;
   assign m1_gnt = gnt1;

   // A read granted just before reset must never surface, even in the reset cycle itself.
   assign m0_rvalid = rvalid0_q & ~rst;
   assign m1_rvalid = rvalid1_q & ~rst;
   assign m0_rdata  = m0_rvalid ? s_rdata : 32'h0;
   assign m1_rdata  = m1_rvalid ? s_rdata : 32'h0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter (MAX_BURST=4) with a synchronous RAM model on the slave side.
// Stimulus pushes expected grants and read words; a negedge monitor pops and compares.
module tb_data_bus_arbiter;
   localparam int AW = 32;
   localparam logic [31:0] W10 = 32'hC0041234;
   localparam logic [31:0] W20 = 32'hC0081234;
   localparam logic [31:0] W40M = 32'hC010BEEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_lock, m1_req, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr, s_addr;
   logic [31:0]   m0_wdata, m1_wdata, s_wdata, s_rdata;
   logic [3:0]    m0_wenable, m1_wenable, s_wenable;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0]   m0_rdata, m1_rdata;

   data_bus_arbiter #(.MAX_BURST(4), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wenable(m0_wenable), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wenable(m1_wenable), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wenable(s_wenable), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: word index from address bits [7:2], byte-enabled writes.
   logic [31:0] mem [0:63];
   initial for (int i = 0; i < 64; i++) mem[i] = {8'hC0, 8'(i), 16'h1234};
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (s_wenable[b]) mem[s_addr[7:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
      s_rdata <= mem[s_addr[7:2]];
   end

   typedef struct {
      logic        mst;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
   } gnt_t;

   gnt_t        gq[$];
   logic [31:0] rq0[$];
   logic [31:0] rq1[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic        exp_rv0 = 1'b0;
   logic        exp_rv1 = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_g(input logic mst, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      gnt_t e;
      e.mst = mst; e.addr = a; e.we = we; e.wdata = wd;
      gq.push_back(e);
   endtask

   task automatic set0(input logic r, input logic l, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      m0_req = r; m0_lock = l; m0_addr = a; m0_wenable = we; m0_wdata = wd;
   endtask

   task automatic set1(input logic r, input logic l, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      m1_req = r; m1_lock = l; m1_addr = a; m1_wenable = we; m1_wdata = wd;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      logic nxt0, nxt1;
      gnt_t e;
      nxt0 = 1'b0;
      nxt1 = 1'b0;
      if (rst) begin
         chk("reset_outputs", {56'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_wenable}, 64'h0);
      end else begin
         if (exp_rv0 || m0_rvalid) chk("m0_rvalid_timing", m0_rvalid, exp_rv0);
         if (exp_rv1 || m1_rvalid) chk("m1_rvalid_timing", m1_rvalid, exp_rv1);
         if (m0_rvalid) begin
            if (rq0.size() == 0) chk("m0_unexpected_rvalid", 1, 0);
            else chk("m0_rdata", m0_rdata, rq0.pop_front());
         end else chk("m0_rdata_zero", m0_rdata, 0);
         if (m1_rvalid) begin
            if (rq1.size() == 0) chk("m1_unexpected_rvalid", 1, 0);
            else chk("m1_rdata", m1_rdata, rq1.pop_front());
         end else chk("m1_rdata_zero", m1_rdata, 0);
         if (m0_gnt && m1_gnt) begin
            chk("double_grant", 1, 0);
         end else if (m0_gnt || m1_gnt) begin
            if (gq.size() == 0) begin
               chk("unexpected_grant", {m1_gnt, m0_gnt}, 0);
            end else begin
               e = gq.pop_front();
               chk("grant_master", m1_gnt, e.mst);
               chk("s_addr", s_addr, e.addr);
               chk("s_wenable", s_wenable, e.we);
               if (e.we != 4'b0) chk("s_wdata", s_wdata, e.wdata);
            end
            nxt0 = m0_gnt && (m0_wenable == 4'b0);
            nxt1 = m1_gnt && (m1_wenable == 4'b0);
         end else begin
            chk("idle_bus", {s_wenable, s_addr, s_wdata}, {4'b0, m0_addr, m0_wdata});
         end
      end
      exp_rv0 = nxt0;
      exp_rv1 = nxt1;
   end

   initial begin
      rst = 1'b1;
      set0(0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Tie after reset: alternate starting with m0
      set0(1, 0, 32'h10, 0, 0);
      set1(1, 0, 32'h20, 0, 0);
      for (int i = 0; i < 2; i++) begin
         exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
         exp_g(1, 32'h20, 0, 0); rq1.push_back(W20); tick;
      end
      set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); tick;

      // Locked burst capped at 4 beats, then m1 once, then m0 again
      set0(1, 1, 32'h10, 0, 0);
      set1(1, 0, 32'h20, 0, 0);
      for (int i = 0; i < 4; i++) begin
         exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
      end
      exp_g(1, 32'h20, 0, 0); rq1.push_back(W20); tick;
      exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
      set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); tick;

      // Short lock: drop lock with the 2nd beat; m1 ignored while owned, then wins
      set0(1, 1, 32'h10, 0, 0);
      exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
      set0(1, 0, 32'h10, 0, 0);
      set1(1, 0, 32'h20, 0, 0);
      exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
      set0(0, 0, 0, 0, 0);
      exp_g(1, 32'h20, 0, 0); rq1.push_back(W20); tick;
      set1(0, 0, 0, 0, 0); tick;

      // Partial write then read-back of the merged word
      set1(1, 0, 32'h40, 4'b0011, 32'hDEADBEEF);
      exp_g(1, 32'h40, 4'b0011, 32'hDEADBEEF); tick;
      set1(0, 0, 0, 0, 0);
      set0(1, 0, 32'h40, 0, 0);
      exp_g(0, 32'h40, 0, 0); rq0.push_back(W40M); tick;
      set0(0, 0, 0, 0, 0); tick;

      // Reset while m0 owns the bus with a read in flight
      set0(1, 1, 32'h10, 0, 0);
      exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
      set0(1, 1, 32'h20, 0, 0);
      exp_g(0, 32'h20, 0, 0); tick;
      rst = 1'b1;
      set0(1, 0, 32'h10, 0, 0);
      set1(1, 0, 32'h20, 0, 0);
      tick;
      rst = 1'b0;
      exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
      exp_g(1, 32'h20, 0, 0); rq1.push_back(W20); tick;
      set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); tick;

      // Idle bus, then a tie shows last_grant (m1) was kept
      repeat (10) tick;
      set0(1, 0, 32'h10, 0, 0);
      set1(1, 0, 32'h20, 0, 0);
      exp_g(0, 32'h10, 0, 0); rq0.push_back(W10); tick;
      set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
      repeat (3) tick;

      chk("grants_left", gq.size(), 0);
      chk("m0_reads_left", rq0.size(), 0);
      chk("m1_reads_left", rq1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
